// File: rtl/count_ctrl_if.sv
// Board-side bundle for count_ctrl: raw keys/switches in, counter strobes and FSM state out.
// The design takes the slave view; whatever drives the keys and consumes the strobes takes master.
interface count_ctrl_if;
  logic [3:0]  KEY;
  logic [17:0] sw;
  logic        cnt_en;
  logic        cnt_up;
  logic        cnt_clr;
  logic        cnt_load;
  logic [15:0] load_val;
  logic [1:0]  state;

  modport master (
    output KEY, sw,
    input  cnt_en, cnt_up, cnt_clr, cnt_load, load_val, state
  );

  modport slave (
    input  KEY, sw,
    output cnt_en, cnt_up, cnt_clr, cnt_load, load_val, state
  );
endinterface

// File: rtl/count_ctrl.sv
// count_ctrl: key conditioning, IDLE/RUN/PAUSE sequencer and prescaler for the counter datapath.
// Key pin to strobe is 3 + DEBOUNCE_CYCLES cycles; no backpressure, every strobe is a single fire-and-forget cycle.
module count_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 50000000,
  parameter int TICK_DIV_FAST   = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  count_ctrl_if.slave bus
);
  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MAX_DIV = (TICK_DIV > TICK_DIV_FAST) ? TICK_DIV : TICK_DIV_FAST;
  localparam int PW      = $clog2(MAX_DIV);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] DIV_M1      = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] DIV_FAST_M1 = PW'(TICK_DIV_FAST - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;

  logic [3:0]    key_s1, key_s2, key_db, key_db_d, armed, press;
  logic [DW-1:0] db_cnt [4];
  logic [1:0]    sw_s1, sw_s2;

  // Sync flops clear to 0, so a key held through reset never looks released and
  // stays disarmed until it is actually seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1   <= '0;
      key_s2   <= '0;
      key_db   <= '1;
      key_db_d <= '1;
      armed    <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      key_s1   <= bus.KEY;
      key_s2   <= key_s1;
      sw_s1    <= bus.sw[17:16];
      sw_s2    <= sw_s1;
      key_db_d <= key_db;
      armed    <= armed | key_s2;
      for (int i = 0; i < 4; i++) begin
        if (key_s2[i] == key_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          key_db[i] <= key_s2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign press = armed & key_db_d & ~key_db;

  state_t        st, st_n;
  logic [PW-1:0] presc, presc_n, div_m1;
  logic          tick;
  logic          en_q, clr_q, load_q, up_q;
  logic          en_n, clr_n, load_n;
  logic [15:0]   lv_q, lv_n;

  // Event priority is clear > load > start > step; losers are simply dropped.
  always_comb begin
    div_m1  = sw_s2[1] ? DIV_FAST_M1 : DIV_M1;
    tick    = (st == RUN) && (presc >= div_m1);
    st_n    = st;
    presc_n = presc;
    en_n    = 1'b0;
    clr_n   = 1'b0;
    load_n  = 1'b0;
    lv_n    = lv_q;
    if (st == RUN) begin
      presc_n = tick ? '0 : presc + PW'(1);
      en_n    = tick;
    end
    if (press[1]) begin
      clr_n   = 1'b1;
      en_n    = 1'b0;
      st_n    = IDLE;
      presc_n = '0;
    end else if (press[2]) begin
      if (st != RUN) begin
        load_n = 1'b1;
        lv_n   = bus.sw[15:0];
      end
    end else if (press[0]) begin
      case (st)
        IDLE: begin
          st_n    = RUN;
          presc_n = '0;
        end
        RUN: begin
          st_n = PAUSE;
          en_n = 1'b0;
        end
        default: st_n = RUN;
      endcase
    end else if (press[3] && st == PAUSE) begin
      en_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      presc  <= '0;
      en_q   <= 1'b0;
      clr_q  <= 1'b0;
      load_q <= 1'b0;
      up_q   <= 1'b0;
      lv_q   <= '0;
    end else begin
      st     <= st_n;
      presc  <= presc_n;
      en_q   <= en_n;
      clr_q  <= clr_n;
      load_q <= load_n;
      up_q   <= sw_s2[0];
      lv_q   <= lv_n;
    end
  end

  assign bus.cnt_en   = en_q;
  assign bus.cnt_up   = up_q;
  assign bus.cnt_clr  = clr_q;
  assign bus.cnt_load = load_q;
  assign bus.load_val = lv_q;
  assign bus.state    = st;
endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl with short debounce/prescale parameters; strobes are matched
// against an expected-event queue keyed by cycle number.
module tb_count_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  count_ctrl_if bus();

  count_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV(5), .TICK_DIV_FAST(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
    logic [15:0] val;
  } ev_t;

  localparam logic [1:0] K_EN = 2'd0, K_CLR = 2'd1, K_LOAD = 2'd2, K_NONE = 2'd3;
  localparam ev_t NO_EV = '{kind: 2'd3, cyc: 32'd0, val: 16'd0};

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc = 0;
  int  en_seen = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic expect_ev(input logic [1:0] kind, input int c, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.cyc  = 32'(c);
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit after the edge, record any strobe seen.
  task automatic adv();
    ev_t o;
    @(posedge clk);
    #1;
    cyc++;
    o.cyc = 32'(cyc);
    o.val = 16'h0;
    if (bus.cnt_en === 1'b1) begin o.kind = K_EN; obs_q.push_back(o); en_seen++; end
    if (bus.cnt_clr === 1'b1) begin o.kind = K_CLR; obs_q.push_back(o); end
    if (bus.cnt_load === 1'b1) begin o.kind = K_LOAD; o.val = bus.load_val; obs_q.push_back(o); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.KEY = 4'hF;
    bus.sw  = 18'h1_0000;
    repeat (3) adv();
    n_checks++; if (bus.state !== 2'b00) begin n_errors++; $display("FAIL reset_state: got %b want 00", bus.state); end
    n_checks++; if (bus.cnt_en !== 1'b0) begin n_errors++; $display("FAIL reset_en: got %b want 0", bus.cnt_en); end
    n_checks++; if (bus.cnt_clr !== 1'b0) begin n_errors++; $display("FAIL reset_clr: got %b want 0", bus.cnt_clr); end
    n_checks++; if (bus.cnt_load !== 1'b0) begin n_errors++; $display("FAIL reset_load: got %b want 0", bus.cnt_load); end
    n_checks++; if (bus.cnt_up !== 1'b0) begin n_errors++; $display("FAIL reset_up: got %b want 0", bus.cnt_up); end
    n_checks++; if (bus.load_val !== 16'h0) begin n_errors++; $display("FAIL reset_load_val: got %h want 0000", bus.load_val); end
    rst = 1'b0;
    repeat (6) adv();
    n_checks++; if (bus.cnt_up !== 1'b1) begin n_errors++; $display("FAIL reset_up_follow: got %b want 1", bus.cnt_up); end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e, o;
      e = NO_EV; o = NO_EV;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL reset_sb: got kind=%0d cyc=%0d val=%h want kind=%0d cyc=%0d val=%h", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val); end
    end
  endtask

  task automatic test_glitch();
    bus.KEY[0] = 1'b0;
    repeat (3) adv();
    bus.KEY[0] = 1'b1;
    repeat (12) adv();
    n_checks++; if (bus.state !== 2'b00) begin n_errors++; $display("FAIL glitch_state: got %b want 00", bus.state); end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e, o;
      e = NO_EV; o = NO_EV;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL glitch_sb: got kind=%0d cyc=%0d val=%h want kind=%0d cyc=%0d val=%h", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val); end
    end
  endtask

  task automatic test_start_run();
    int b;
    b = cyc;
    bus.KEY[0] = 1'b0;
    for (int k = 1; k <= 4; k++) expect_ev(K_EN, b + 7 + 5 * k, 16'h0);
    for (int i = 1; i <= 27; i++) begin
      adv();
      if (i == 6) begin
        n_checks++; if (bus.state !== 2'b00) begin n_errors++; $display("FAIL start_early: got %b want 00", bus.state); end
      end
      if (i == 7) begin
        n_checks++; if (bus.state !== 2'b01) begin n_errors++; $display("FAIL start_latency: got %b want 01", bus.state); end
        en_seen = 0;
      end
      if (i == 10) bus.KEY[0] = 1'b1;
    end
    n_checks++; if (en_seen !== 4) begin n_errors++; $display("FAIL run_tick_count: got %0d want 4", en_seen); end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e, o;
      e = NO_EV; o = NO_EV;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL start_sb: got kind=%0d cyc=%0d val=%h want kind=%0d cyc=%0d val=%h", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val); end
    end
  endtask

  // Entered right after a slow tick; fast mode takes effect once synchronized,
  // and the pause press lands on a tick cycle, which must be swallowed.
  task automatic test_fast_pause();
    int t;
    t = cyc;
    bus.sw[17] = 1'b1;
    bus.sw[16] = 1'b0;
    for (int k = 3; k <= 13; k += 2) expect_ev(K_EN, t + k, 16'h0);
    for (int i = 1; i <= 24; i++) begin
      adv();
      if (i == 2) begin
        n_checks++; if (bus.cnt_up !== 1'b1) begin n_errors++; $display("FAIL up_early: got %b want 1", bus.cnt_up); end
      end
      if (i == 3) begin
        n_checks++; if (bus.cnt_up !== 1'b0) begin n_errors++; $display("FAIL up_latency: got %b want 0", bus.cnt_up); end
      end
      if (i == 8) bus.KEY[0] = 1'b0;
      if (i == 14) begin
        bus.KEY[0] = 1'b1;
        n_checks++; if (bus.state !== 2'b01) begin n_errors++; $display("FAIL pause_early: got %b want 01", bus.state); end
      end
      if (i == 15) begin
        n_checks++; if (bus.state !== 2'b10) begin n_errors++; $display("FAIL pause_entry: got %b want 10", bus.state); end
      end
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e, o;
      e = NO_EV; o = NO_EV;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL fast_sb: got kind=%0d cyc=%0d val=%h want kind=%0d cyc=%0d val=%h", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val); end
    end
  endtask

  task automatic test_step();
    int s;
    s = cyc;
    bus.KEY[3] = 1'b0;
    expect_ev(K_EN, s + 7, 16'h0);
    for (int i = 1; i <= 16; i++) begin
      adv();
      if (i == 6) bus.KEY[3] = 1'b1;
    end
    n_checks++; if (bus.state !== 2'b10) begin n_errors++; $display("FAIL step_state: got %b want 10", bus.state); end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e, o;
      e = NO_EV; o = NO_EV;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL step_sb: got kind=%0d cyc=%0d val=%h want kind=%0d cyc=%0d val=%h", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val); end
    end
  endtask

  task automatic test_clear_priority();
    int c;
    bus.sw[15:0] = 16'hBEEF;
    c = cyc;
    bus.KEY[2:1] = 2'b00;
    expect_ev(K_CLR, c + 7, 16'h0);
    for (int i = 1; i <= 16; i++) begin
      adv();
      if (i == 6) begin
        bus.KEY[2:1] = 2'b11;
        n_checks++; if (bus.state !== 2'b10) begin n_errors++; $display("FAIL clr_early: got %b want 10", bus.state); end
      end
      if (i == 7) begin
        n_checks++; if (bus.state !== 2'b00) begin n_errors++; $display("FAIL clr_state: got %b want 00", bus.state); end
        n_checks++; if (bus.cnt_load !== 1'b0) begin n_errors++; $display("FAIL clr_no_load: got %b want 0", bus.cnt_load); end
      end
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e, o;
      e = NO_EV; o = NO_EV;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL clr_sb: got kind=%0d cyc=%0d val=%h want kind=%0d cyc=%0d val=%h", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val); end
    end
  endtask

  task automatic test_idle_load();
    int c;
    bus.sw[15:0] = 16'h1234;
    c = cyc;
    bus.KEY[2] = 1'b0;
    expect_ev(K_LOAD, c + 7, 16'h1234);
    for (int i = 1; i <= 16; i++) begin
      adv();
      if (i == 6) bus.KEY[2] = 1'b1;
      if (i == 7) begin
        n_checks++; if (bus.cnt_load !== 1'b1) begin n_errors++; $display("FAIL load_strobe: got %b want 1", bus.cnt_load); end
        n_checks++; if (bus.load_val !== 16'h1234) begin n_errors++; $display("FAIL load_val: got %h want 1234", bus.load_val); end
      end
    end
    n_checks++; if (bus.state !== 2'b00) begin n_errors++; $display("FAIL load_state: got %b want 00", bus.state); end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e, o;
      e = NO_EV; o = NO_EV;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL load_sb: got kind=%0d cyc=%0d val=%h want kind=%0d cyc=%0d val=%h", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val); end
    end
  endtask

  // Ends in slow RUN with the prescaler at 3 and KEY[0] already held low.
  task automatic test_run_load();
    int r;
    r = cyc;
    bus.KEY[0] = 1'b0;
    for (int k = 9; k <= 21; k += 2) expect_ev(K_EN, r + k, 16'h0);
    for (int i = 1; i <= 24; i++) begin
      adv();
      if (i == 6) bus.KEY[0] = 1'b1;
      if (i == 7) begin
        n_checks++; if (bus.state !== 2'b01) begin n_errors++; $display("FAIL run_entry: got %b want 01", bus.state); end
      end
      if (i == 11) bus.KEY[2] = 1'b0;
      if (i == 17) bus.KEY[2] = 1'b1;
      if (i == 18) begin
        n_checks++; if (bus.cnt_load !== 1'b0) begin n_errors++; $display("FAIL run_load_ignored: got %b want 0", bus.cnt_load); end
      end
      if (i == 19) bus.sw[17] = 1'b0;
      if (i == 22) bus.KEY[0] = 1'b0;
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e, o;
      e = NO_EV; o = NO_EV;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL run_load_sb: got kind=%0d cyc=%0d val=%h want kind=%0d cyc=%0d val=%h", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val); end
    end
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1;
    adv();
    rst = 1'b0;
    n_checks++; if (bus.state !== 2'b00) begin n_errors++; $display("FAIL midrst_state: got %b want 00", bus.state); end
    n_checks++; if (bus.cnt_en !== 1'b0) begin n_errors++; $display("FAIL midrst_en: got %b want 0", bus.cnt_en); end
    n_checks++; if (bus.cnt_clr !== 1'b0) begin n_errors++; $display("FAIL midrst_clr: got %b want 0", bus.cnt_clr); end
    n_checks++; if (bus.cnt_load !== 1'b0) begin n_errors++; $display("FAIL midrst_load: got %b want 0", bus.cnt_load); end
    n_checks++; if (bus.load_val !== 16'h0) begin n_errors++; $display("FAIL midrst_load_val: got %h want 0000", bus.load_val); end
    for (int i = 2; i <= 40; i++) begin
      adv();
      if (i == 20) begin
        n_checks++; if (bus.state !== 2'b00) begin n_errors++; $display("FAIL held_key_no_start: got %b want 00", bus.state); end
        bus.KEY[0] = 1'b1;
      end
      if (i == 30) bus.KEY[0] = 1'b0;
      if (i == 36) begin
        n_checks++; if (bus.state !== 2'b00) begin n_errors++; $display("FAIL repress_early: got %b want 00", bus.state); end
        bus.KEY[0] = 1'b1;
      end
      if (i == 37) begin
        n_checks++; if (bus.state !== 2'b01) begin n_errors++; $display("FAIL repress_start: got %b want 01", bus.state); end
      end
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e, o;
      e = NO_EV; o = NO_EV;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL midrst_sb: got kind=%0d cyc=%0d val=%h want kind=%0d cyc=%0d val=%h", o.kind, o.cyc, o.val, e.kind, e.cyc, e.val); end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_start_run();
    test_fast_pause();
    test_step();
    test_clear_priority();
    test_idle_load();
    test_run_load();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
- Control sequencer for the board-level counter datapath.
- Conditions the four push buttons: 2-FF synchronizer, debounce, press-edge detect.
- Runs an IDLE/RUN/PAUSE state machine and a prescaler.
- Drives single-cycle clear/load/enable strobes, count direction and load value to the counter; the counter and the 7-segment decode sit downstream.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required before a key change is accepted (10 ms at 50 MHz); minimum 1.
TICK_DIV, 50000000, clk cycles per cnt_en pulse in RUN, normal speed; minimum 2.
TICK_DIV_FAST, 5000000, clk cycles per cnt_en pulse in RUN when fast mode is selected; minimum 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
KEY  input  4  push buttons, active-low (0 = pressed): [0] start/pause, [1] clear, [2] load, [3] single step
sw  input  18  slide switches: [15:0] load value, [16] direction (1 = up), [17] fast mode
cnt_en  output  1  one-cycle count-enable strobe
cnt_up  output  1  count direction, valid whenever cnt_en is high
cnt_clr  output  1  one-cycle clear strobe
cnt_load  output  1  one-cycle load strobe
load_val  output  16  value to load, valid while cnt_load is high
state  output  2  00 IDLE, 01 RUN, 10 PAUSE; 11 never driven

Behaviour:
- Reset values:
  - state = IDLE; all strobes 0; cnt_up = 0; load_val = 0.
  - Prescaler, debounce counters and sync flops cleared.
  - Debounced key state = released (1).
- Reset mid-operation: everything returns to reset values the next cycle. A key held through reset produces no press event until it is released and pressed again.
- Synchronizers: 2-FF on KEY[3:0] and sw[17:16]. sw[15:0] is sampled directly; it is quasi-static.
- Debounce, per key:
  - The counter increments while the synchronized value differs from the debounced value, and resets to 0 when they match.
  - On reaching DEBOUNCE_CYCLES the debounced value flips and the counter resets.
- Press event: debounced 1->0 transition, a one-cycle pulse. Release produces no event.
- Pin-to-event latency is 2 + DEBOUNCE_CYCLES cycles; strobes follow one cycle later.
- Same-cycle event priority: clear > load > start > step. Lower-priority events in that cycle are dropped, not queued.
- FSM transitions:
  - clear, any state: cnt_clr = 1, next state IDLE, prescaler <= 0.
  - load in IDLE or PAUSE: cnt_load = 1, load_val <= sw[15:0] (same cycle), state unchanged. Load in RUN is ignored; no strobe.
  - start: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  - Entering RUN from IDLE resets the prescaler to 0. Resuming from PAUSE keeps the held prescaler value.
  - step in PAUSE: one cnt_en pulse. Step is ignored in IDLE and RUN.
- Prescaler:
  - Counts only in RUN. DIV = TICK_DIV_FAST if synced sw[17] = 1, else TICK_DIV.
  - When the count is >= DIV-1: cnt_en = 1, prescaler <= 0. Otherwise the prescaler increments.
  - The >= comparison makes a switch to fast mode mid-period wrap safely.
  - Width is clog2(max(TICK_DIV, TICK_DIV_FAST)).
- Strobe exclusivity:
  - At most one of cnt_clr / cnt_load / cnt_en is high in any cycle.
  - A prescaler tick coinciding with clear is suppressed.
  - A tick coinciding with start-to-PAUSE is suppressed.
- cnt_up: registered copy of synced sw[16], updated every cycle.
- All outputs are registered.

Test Plan:
(bench params: DEBOUNCE_CYCLES=4, TICK_DIV=5, TICK_DIV_FAST=2)
- Reset, then KEY[0] low for 3 cycles (glitch) -> no event; state stays 00; no strobes.
- KEY[0] held low 10 cycles -> state 01 exactly 7 cycles after the falling edge. Then cnt_en pulses every 5 cycles; 4 pulses in 20 cycles.
- RUN with sw[17]=1 (after sync) -> cnt_en every 2 cycles. sw[16]=0 -> cnt_up = 0 at 3 cycles after the change.
- In PAUSE with sw[15:0]=16'hBEEF, KEY[2] and KEY[1] pressed together -> only cnt_clr pulses; state 00; no cnt_load.
- PAUSE then KEY[3] press -> exactly one cnt_en. In RUN, KEY[2] press -> no cnt_load. In IDLE, KEY[2] with sw[15:0]=16'h1234 -> cnt_load = 1 and load_val = 16'h1234.
- rst asserted mid-RUN with the prescaler at 3 -> next cycle state 00, no strobes. KEY[0] still held through reset -> no start until it is released and pressed again.
